simplez_mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single 512x12 main memory of the SIMPLEZ microcontroller between the CPU (port A) and a loader/debug master (port B), for example a UART program loader.
- Serialises accesses, drives the memory write strobe and captures read data per port.
- Sits between the requesters and the memory instance; memory-mapped peripherals decode downstream from mem_addr.

---
 rtl/simplez_mem_arbiter_if.sv | 61 ++++++
 rtl/simplez_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_simplez_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simplez_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// simplez_mem_arbiter_if
// Bus bundle between the two requesters (CPU on port A, loader/debug master
// on port B), the shared 512x12 SIMPLEZ main memory and the arbiter.
//
//   a_req/a_we/a_addr/a_wdata   port A request, held stable until a_ack
//   a_ack/a_rdata               port A completion pulse and read data
//   b_*                         same set for port B
//   mem_addr/mem_we/mem_wdata   memory address, write strobe, write data
//   mem_rdata                   memory read data, one cycle after mem_addr
//   busy                        arbiter is serving a transaction
//   owner                       port currently/last granted (0 = A, 1 = B)
//
// Modports: slave = arbiter side, master = requesters + memory side.
// ---------------------------------------------------------------------------
interface simplez_mem_arbiter_if #(
    parameter int DATAW = 12,
    parameter int ADDRW = 9
);
    logic             a_req;
    logic             a_we;
    logic [ADDRW-1:0] a_addr;
    logic [DATAW-1:0] a_wdata;
    logic             a_ack;
    logic [DATAW-1:0] a_rdata;

    logic             b_req;
    logic             b_we;
    logic [ADDRW-1:0] b_addr;
    logic [DATAW-1:0] b_wdata;
    logic             b_ack;
    logic [DATAW-1:0] b_rdata;

    logic [ADDRW-1:0] mem_addr;
    logic             mem_we;
    logic [DATAW-1:0] mem_wdata;
    logic [DATAW-1:0] mem_rdata;

    logic             busy;
    logic             owner;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/simplez_mem_arbiter.sv
// ---------------------------------------------------------------------------
// simplez_mem_arbiter
// Shares the single SIMPLEZ main memory between the CPU (port A) and a
// loader/debug master (port B). One access at a time: the winner's
// we/addr/wdata are latched in IDLE, the memory is driven in ACC, read data
// is captured at the end of RD, and the winner gets a one-cycle ack in ACK.
//
// Ports:
//   clk   system clock; all registers update on the falling edge so the
//         arbiter lines up with the CPU datapath
//   rst   synchronous, active-high reset; aborts any transaction in flight
//   bus   simplez_mem_arbiter_if.slave (requester ports, memory port,
//         busy/owner status)
//
// Parameters:
//   DATAW       memory word width
//   ADDRW       memory address width
//   FIXED_PRIO  0 = alternate between A and B on ties, 1 = B wins ties
// ---------------------------------------------------------------------------
module simplez_mem_arbiter #(
    parameter int DATAW      = 12,
    parameter int ADDRW      = 9,
    parameter int FIXED_PRIO = 0
) (
    input logic                  clk,
    input logic                  rst,
    simplez_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             grant_b;
    logic             latch_en;

    logic             lat_we;
    logic [ADDRW-1:0] lat_addr;
    logic [DATAW-1:0] lat_wdata;
    logic             owner_q;
    logic             a_ack_q;
    logic             b_ack_q;
    logic [DATAW-1:0] a_rdata_q;
    logic [DATAW-1:0] b_rdata_q;

    // Next state and arbitration. Requests are only looked at in IDLE; in
    // every other state the requester inputs are ignored entirely.
    always_comb begin
        state_nxt = state;
        grant_b   = owner_q;
        latch_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    latch_en = 1'b1;
                    if (bus.a_req && bus.b_req) begin
                        // On a tie, round-robin hands the grant to whoever
                        // did not win last time.
                        grant_b = (FIXED_PRIO != 0) ? 1'b1 : !owner_q;
                    end else begin
                        grant_b = bus.b_req;
                    end
                    state_nxt = ACC;
                end
            end
            ACC:     state_nxt = lat_we ? ACK : RD;
            RD:      state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_q   <= 1'b1;  // so port A wins the first round-robin tie
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state <= state_nxt;

            // Ack is registered: raised on the edge that enters ACK, so it
            // is high for exactly the ACK cycle. owner_q is already stable
            // by then because it was set on the IDLE latch edge.
            a_ack_q <= (state_nxt == ACK) && !owner_q;
            b_ack_q <= (state_nxt == ACK) && owner_q;

            if (latch_en) begin
                owner_q   <= grant_b;
                lat_we    <= grant_b ? bus.b_we    : bus.a_we;
                lat_addr  <= grant_b ? bus.b_addr  : bus.a_addr;
                lat_wdata <= grant_b ? bus.b_wdata : bus.a_wdata;
            end

            // mem_rdata answers the address sampled at the end of ACC, so
            // it is valid throughout RD; only the owner's register moves.
            if (state == RD) begin
                if (owner_q) begin
                    b_rdata_q <= bus.mem_rdata;
                end else begin
                    a_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    // The write strobe is decoded from state so that a reset during ACC
    // drops it on the same edge.
    assign bus.mem_we    = (state == ACC) && lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_simplez_mem_arbiter
// Two arbiter instances share the stimulus signal arrays: index 0 is the
// round-robin build (FIXED_PRIO=0), index 1 the fixed-priority build.
// Each has its own 512-word memory model. The DUT updates on the falling
// edge; the bench samples outputs and drives inputs on the rising edge.
// ---------------------------------------------------------------------------
module tb_simplez_mem_arbiter;
    localparam int DATAW = 12;
    localparam int ADDRW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            rst_d;
    logic [1:0]            a_req_d, a_we_d, b_req_d, b_we_d;
    logic [1:0][ADDRW-1:0] a_addr_d, b_addr_d;
    logic [1:0][DATAW-1:0] a_wdata_d, b_wdata_d, mem_rdata_d;
    logic [1:0]            a_ack_o, b_ack_o, mem_we_o, busy_o, owner_o;
    logic [1:0][DATAW-1:0] a_rdata_o, b_rdata_o, mem_wdata_o;
    logic [1:0][ADDRW-1:0] mem_addr_o;

    simplez_mem_arbiter_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].a_req     = a_req_d[g];
        assign bus[g].a_we      = a_we_d[g];
        assign bus[g].a_addr    = a_addr_d[g];
        assign bus[g].a_wdata   = a_wdata_d[g];
        assign bus[g].b_req     = b_req_d[g];
        assign bus[g].b_we      = b_we_d[g];
        assign bus[g].b_addr    = b_addr_d[g];
        assign bus[g].b_wdata   = b_wdata_d[g];
        assign bus[g].mem_rdata = mem_rdata_d[g];
        assign a_ack_o[g]       = bus[g].a_ack;
        assign b_ack_o[g]       = bus[g].b_ack;
        assign a_rdata_o[g]     = bus[g].a_rdata;
        assign b_rdata_o[g]     = bus[g].b_rdata;
        assign mem_addr_o[g]    = bus[g].mem_addr;
        assign mem_we_o[g]      = bus[g].mem_we;
        assign mem_wdata_o[g]   = bus[g].mem_wdata;
        assign busy_o[g]        = bus[g].busy;
        assign owner_o[g]       = bus[g].owner;

        simplez_mem_arbiter #(.DATAW(DATAW), .ADDRW(ADDRW), .FIXED_PRIO(g)) dut (
            .clk(clk),
            .rst(rst_d[g]),
            .bus(bus[g])
        );
    end

    // Synchronous memory: samples address (and write) on the falling edge,
    // read data appears one cycle later.
    logic [DATAW-1:0] mem [2][512];
    logic             load;
    logic             poke;
    int               poke_p;
    logic [ADDRW-1:0] poke_addr;
    logic [DATAW-1:0] poke_data;

    function automatic logic [DATAW-1:0] pat(input int p, input int i);
        return 12'((i * 173 + p * 59 + 11) ^ (i << 3));
    endfunction

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (load) begin
                for (int i = 0; i < 512; i++) mem[p][i] <= pat(p, i);
            end else begin
                if (poke && poke_p == p) mem[p][poke_addr] <= poke_data;
                if (mem_we_o[p]) mem[p][mem_addr_o[p]] <= mem_wdata_o[p];
            end
            mem_rdata_d[p] <= mem[p][mem_addr_o[p]];
        end
    end

    // Reference state: memory contents and each port's expected rdata.
    logic [DATAW-1:0] shadow    [2][512];
    logic [DATAW-1:0] exp_rdata [2][2];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic poke_mem(input int p, input logic [ADDRW-1:0] addr, input logic [DATAW-1:0] data);
        poke_p = p; poke_addr = addr; poke_data = data; poke = 1'b1;
        @(posedge clk);
        poke = 1'b0;
        shadow[p][addr] = data;
    endtask

    task automatic do_reset(input int p);
        rst_d[p] = 1'b1; a_req_d[p] = 1'b0; b_req_d[p] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst_d[p] = 1'b0;
        exp_rdata[p][0] = '0;
        exp_rdata[p][1] = '0;
    endtask

    task automatic test_reset();
        rst_d = 2'b11; a_req_d = '0; b_req_d = '0;
        @(posedge clk);
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            n_cmp++; if ({busy_o[p], a_ack_o[p], b_ack_o[p], mem_we_o[p]} !== 4'b0000) begin
                n_bad++; $display("FAIL reset_ctrl[%0d]: busy/a_ack/b_ack/mem_we got %b want 0000", p,
                                  {busy_o[p], a_ack_o[p], b_ack_o[p], mem_we_o[p]}); end
            n_cmp++; if (owner_o[p] !== 1'b1) begin
                n_bad++; $display("FAIL reset_owner[%0d]: got %b want 1", p, owner_o[p]); end
            n_cmp++; if (a_rdata_o[p] !== 12'o0 || b_rdata_o[p] !== 12'o0) begin
                n_bad++; $display("FAIL reset_rdata[%0d]: got a=%o b=%o want 0", p, a_rdata_o[p], b_rdata_o[p]); end
            n_cmp++; if (mem_addr_o[p] !== 9'o0) begin
                n_bad++; $display("FAIL reset_mem_addr[%0d]: got %o want 0", p, mem_addr_o[p]); end
            exp_rdata[p][0] = '0;
            exp_rdata[p][1] = '0;
        end
        rst_d = 2'b00;
    endtask

    task automatic test_a_read();
        int busy_cnt = 0, ack_cnt = 0, ack_at = -1, b_cnt = 0;
        poke_mem(0, 9'o005, 12'o1234);
        a_we_d[0] = 1'b0; a_addr_d[0] = 9'o005; a_req_d[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            if (busy_o[0]) busy_cnt++;
            if (a_ack_o[0]) begin ack_cnt++; if (ack_at < 0) ack_at = k; end
            if (b_ack_o[0]) b_cnt++;
            if (k == 3) begin
                n_cmp++; if (a_rdata_o[0] !== 12'o1234) begin
                    n_bad++; $display("FAIL a_read_rdata: got %o want 1234", a_rdata_o[0]); end
                a_req_d[0] = 1'b0;
            end
        end
        n_cmp++; if (ack_at != 3 || ack_cnt != 1) begin
            n_bad++; $display("FAIL a_read_ack: first at cycle %0d count %0d, want cycle 3 count 1", ack_at, ack_cnt); end
        n_cmp++; if (busy_cnt != 3) begin
            n_bad++; $display("FAIL a_read_busy: high %0d cycles want 3", busy_cnt); end
        n_cmp++; if (b_cnt != 0) begin
            n_bad++; $display("FAIL a_read_b_ack: b_ack high %0d cycles want 0", b_cnt); end
        exp_rdata[0][0] = 12'o1234;
    endtask

    task automatic test_b_write();
        b_we_d[0] = 1'b1; b_addr_d[0] = 9'o100; b_wdata_d[0] = 12'o0007; b_req_d[0] = 1'b1;
        @(posedge clk);
        n_cmp++; if ({mem_we_o[0], mem_addr_o[0], mem_wdata_o[0], b_ack_o[0]} !== {1'b1, 9'o100, 12'o0007, 1'b0}) begin
            n_bad++; $display("FAIL b_write_acc: we=%b addr=%o wdata=%o ack=%b want 1/100/0007/0",
                              mem_we_o[0], mem_addr_o[0], mem_wdata_o[0], b_ack_o[0]); end
        @(posedge clk);
        n_cmp++; if ({mem_we_o[0], b_ack_o[0], a_ack_o[0]} !== 3'b010) begin
            n_bad++; $display("FAIL b_write_ack: mem_we/b_ack/a_ack got %b want 010",
                              {mem_we_o[0], b_ack_o[0], a_ack_o[0]}); end
        n_cmp++; if (b_rdata_o[0] !== exp_rdata[0][1] || a_rdata_o[0] !== exp_rdata[0][0]) begin
            n_bad++; $display("FAIL b_write_no_capture: a=%o b=%o want a=%o b=%o",
                              a_rdata_o[0], b_rdata_o[0], exp_rdata[0][0], exp_rdata[0][1]); end
        b_req_d[0] = 1'b0;
        @(posedge clk);
        n_cmp++; if ({busy_o[0], b_ack_o[0], mem_we_o[0]} !== 3'b000) begin
            n_bad++; $display("FAIL b_write_idle: busy/b_ack/mem_we got %b want 000",
                              {busy_o[0], b_ack_o[0], mem_we_o[0]}); end
        n_cmp++; if (mem[0][9'o100] !== 12'o0007) begin
            n_bad++; $display("FAIL b_write_mem: got %o want 0007", mem[0][9'o100]); end
        shadow[0][9'o100] = 12'o0007;
    endtask

    task automatic test_addr_change();
        poke_mem(0, 9'o010, 12'o4321);
        poke_mem(0, 9'o020, 12'o0765);
        a_we_d[0] = 1'b0; a_addr_d[0] = 9'o010; a_req_d[0] = 1'b1;
        @(posedge clk);
        n_cmp++; if (mem_addr_o[0] !== 9'o010) begin
            n_bad++; $display("FAIL addr_change_acc: mem_addr got %o want 010", mem_addr_o[0]); end
        a_addr_d[0] = 9'o020; a_we_d[0] = 1'b1; a_wdata_d[0] = 12'o7777;
        @(posedge clk);
        @(posedge clk);
        n_cmp++; if ({a_ack_o[0], a_rdata_o[0]} !== {1'b1, 12'o4321}) begin
            n_bad++; $display("FAIL addr_change_rdata: ack=%b rdata=%o want 1/4321", a_ack_o[0], a_rdata_o[0]); end
        a_req_d[0] = 1'b0;
        @(posedge clk);
        n_cmp++; if (mem[0][9'o020] !== 12'o0765) begin
            n_bad++; $display("FAIL addr_change_nowrite: mem[020]=%o want 0765", mem[0][9'o020]); end
        exp_rdata[0][0] = 12'o4321;
    endtask

    task automatic test_reset_mid();
        int early = 0;
        a_we_d[0] = 1'b0; a_addr_d[0] = 9'o005; a_req_d[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        rst_d[0] = 1'b1;            // sampled on the edge that ends RD
        @(posedge clk);
        n_cmp++; if ({a_ack_o[0], busy_o[0], mem_we_o[0]} !== 3'b000) begin
            n_bad++; $display("FAIL reset_mid_ctrl: a_ack/busy/mem_we got %b want 000",
                              {a_ack_o[0], busy_o[0], mem_we_o[0]}); end
        n_cmp++; if (a_rdata_o[0] !== 12'o0 || mem_addr_o[0] !== 9'o0) begin
            n_bad++; $display("FAIL reset_mid_data: a_rdata=%o mem_addr=%o want 0/0", a_rdata_o[0], mem_addr_o[0]); end
        rst_d[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            if (k < 3 && a_ack_o[0]) early++;
        end
        n_cmp++; if ({a_ack_o[0], a_rdata_o[0]} !== {1'b1, 12'o1234} || early != 0) begin
            n_bad++; $display("FAIL reset_mid_retry: ack=%b rdata=%o early=%0d want 1/1234/0",
                              a_ack_o[0], a_rdata_o[0], early); end
        a_req_d[0] = 1'b0;
        @(posedge clk);
        exp_rdata[0][0] = 12'o1234;
        exp_rdata[0][1] = '0;
    endtask

    task automatic test_round_robin();
        logic [ADDRW-1:0] aa, ba;
        logic w;
        do_reset(0);
        aa = 9'($urandom); ba = 9'($urandom);
        a_we_d[0] = 1'b0; a_addr_d[0] = aa; a_req_d[0] = 1'b1;
        b_we_d[0] = 1'b0; b_addr_d[0] = ba; b_req_d[0] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            w = (g % 2) != 0;       // A, B, A, B
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                if (k == 3) begin
                    exp_rdata[0][w] = shadow[0][w ? ba : aa];
                    n_cmp++; if ({owner_o[0], a_ack_o[0], b_ack_o[0]} !== {w, !w, w}) begin
                        n_bad++; $display("FAIL rr_grant[%0d]: owner/a_ack/b_ack got %b want %b",
                                          g, {owner_o[0], a_ack_o[0], b_ack_o[0]}, {w, !w, w}); end
                    n_cmp++; if (a_rdata_o[0] !== exp_rdata[0][0] || b_rdata_o[0] !== exp_rdata[0][1]) begin
                        n_bad++; $display("FAIL rr_rdata[%0d]: a=%o b=%o want a=%o b=%o", g,
                                          a_rdata_o[0], b_rdata_o[0], exp_rdata[0][0], exp_rdata[0][1]); end
                end
                if (k == 4) begin
                    n_cmp++; if ({busy_o[0], a_ack_o[0], b_ack_o[0]} !== 3'b000) begin
                        n_bad++; $display("FAIL rr_idle[%0d]: busy/a_ack/b_ack got %b want 000",
                                          g, {busy_o[0], a_ack_o[0], b_ack_o[0]}); end
                end
            end
        end
        a_req_d[0] = 1'b0; b_req_d[0] = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_fixed_prio();
        logic [ADDRW-1:0] aa, ba;
        int a_cnt = 0;
        do_reset(1);
        aa = 9'($urandom); ba = 9'($urandom);
        a_we_d[1] = 1'b0; a_addr_d[1] = aa; a_req_d[1] = 1'b1;
        b_we_d[1] = 1'b0; b_addr_d[1] = ba; b_req_d[1] = 1'b1;
        for (int g = 0; g < 3; g++) begin
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                if (a_ack_o[1]) a_cnt++;
                if (k == 3) begin
                    n_cmp++; if ({owner_o[1], b_ack_o[1], b_rdata_o[1]} !== {1'b1, 1'b1, shadow[1][ba]}) begin
                        n_bad++; $display("FAIL fixed_grant[%0d]: owner=%b b_ack=%b b_rdata=%o want 1/1/%o",
                                          g, owner_o[1], b_ack_o[1], b_rdata_o[1], shadow[1][ba]); end
                    if (g == 2) b_req_d[1] = 1'b0;
                end
            end
        end
        n_cmp++; if (a_cnt != 0) begin
            n_bad++; $display("FAIL fixed_a_starved: a_ack seen %0d times want 0", a_cnt); end
        for (int k = 1; k <= 3; k++) @(posedge clk);
        n_cmp++; if ({a_ack_o[1], owner_o[1], a_rdata_o[1]} !== {1'b1, 1'b0, shadow[1][aa]}) begin
            n_bad++; $display("FAIL fixed_a_after: a_ack=%b owner=%b a_rdata=%o want 1/0/%o",
                              a_ack_o[1], owner_o[1], a_rdata_o[1], shadow[1][aa]); end
        a_req_d[1] = 1'b0;
        @(posedge clk);
    endtask

    // Random traffic against a transaction-level model: each access is
    // granted per the tie rule, takes 2 (write) or 3 (read) busy cycles
    // with the ack in the last, and reads return the model memory word.
    task automatic test_random(input int p, input int n);
        logic pa, pb, win, we, own;
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] wd;
        logic [1:0] ack_exp;
        int len;
        do_reset(p);
        own = 1'b1; pa = 1'b0; pb = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1'b1; a_we_d[p] = 1'($urandom); a_addr_d[p] = 9'($urandom); a_wdata_d[p] = 12'($urandom);
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1; b_we_d[p] = 1'($urandom); b_addr_d[p] = 9'($urandom); b_wdata_d[p] = 12'($urandom);
            end
            a_req_d[p] = pa; b_req_d[p] = pb;
            if (!pa && !pb) begin
                @(posedge clk);
                n_cmp++; if ({busy_o[p], a_ack_o[p], b_ack_o[p]} !== 3'b000) begin
                    n_bad++; $display("FAIL rand_quiet[%0d/%0d]: busy/a_ack/b_ack got %b want 000",
                                      p, t, {busy_o[p], a_ack_o[p], b_ack_o[p]}); end
                continue;
            end
            win  = (pa && pb) ? ((p != 0) ? 1'b1 : !own) : pb;
            we   = win ? b_we_d[p] : a_we_d[p];
            addr = win ? b_addr_d[p] : a_addr_d[p];
            wd   = win ? b_wdata_d[p] : a_wdata_d[p];
            len  = we ? 2 : 3;
            for (int k = 1; k <= len; k++) begin
                @(posedge clk);
                if (k == len) begin
                    if (we) shadow[p][addr] = wd;
                    else    exp_rdata[p][win] = shadow[p][addr];
                end
                ack_exp = (k == len) ? (win ? 2'b01 : 2'b10) : 2'b00;
                n_cmp++; if ({busy_o[p], owner_o[p], a_ack_o[p], b_ack_o[p]} !== {1'b1, win, ack_exp}) begin
                    n_bad++; $display("FAIL rand_ctrl[%0d/%0d/%0d]: busy/owner/a_ack/b_ack got %b want %b",
                                      p, t, k, {busy_o[p], owner_o[p], a_ack_o[p], b_ack_o[p]}, {1'b1, win, ack_exp}); end
                n_cmp++; if (a_rdata_o[p] !== exp_rdata[p][0] || b_rdata_o[p] !== exp_rdata[p][1]) begin
                    n_bad++; $display("FAIL rand_rdata[%0d/%0d/%0d]: a=%o b=%o want a=%o b=%o", p, t, k,
                                      a_rdata_o[p], b_rdata_o[p], exp_rdata[p][0], exp_rdata[p][1]); end
                n_cmp++; if (mem_we_o[p] !== ((k == 1) && we)) begin
                    n_bad++; $display("FAIL rand_mem_we[%0d/%0d/%0d]: got %b want %b", p, t, k,
                                      mem_we_o[p], (k == 1) && we); end
                if (k == 1) begin
                    n_cmp++; if (mem_addr_o[p] !== addr || (we && mem_wdata_o[p] !== wd)) begin
                        n_bad++; $display("FAIL rand_mem_bus[%0d/%0d]: addr=%o wdata=%o want %o/%o",
                                          p, t, mem_addr_o[p], mem_wdata_o[p], addr, wd); end
                    // The owner's inputs no longer matter; a late request
                    // from the other port waits for the next IDLE.
                    if (win) begin
                        b_we_d[p] = 1'($urandom); b_addr_d[p] = 9'($urandom); b_wdata_d[p] = 12'($urandom);
                        if (!pa && $urandom_range(0, 1) == 1) begin
                            pa = 1'b1; a_we_d[p] = 1'($urandom); a_addr_d[p] = 9'($urandom);
                            a_wdata_d[p] = 12'($urandom); a_req_d[p] = 1'b1;
                        end
                    end else begin
                        a_we_d[p] = 1'($urandom); a_addr_d[p] = 9'($urandom); a_wdata_d[p] = 12'($urandom);
                        if (!pb && $urandom_range(0, 1) == 1) begin
                            pb = 1'b1; b_we_d[p] = 1'($urandom); b_addr_d[p] = 9'($urandom);
                            b_wdata_d[p] = 12'($urandom); b_req_d[p] = 1'b1;
                        end
                    end
                end
                if (k == len) begin
                    if (win) begin b_req_d[p] = 1'b0; pb = 1'b0; end
                    else     begin a_req_d[p] = 1'b0; pa = 1'b0; end
                end
            end
            own = win;
            @(posedge clk);
            n_cmp++; if ({busy_o[p], a_ack_o[p], b_ack_o[p], mem_we_o[p], owner_o[p], mem_addr_o[p]} !==
                         {4'b0000, win, addr}) begin
                n_bad++; $display("FAIL rand_idle[%0d/%0d]: busy/a_ack/b_ack/mem_we=%b owner=%b mem_addr=%o want 0000/%b/%o",
                                  p, t, {busy_o[p], a_ack_o[p], b_ack_o[p], mem_we_o[p]}, owner_o[p],
                                  mem_addr_o[p], win, addr); end
        end
        a_req_d[p] = 1'b0; b_req_d[p] = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        rst_d = 2'b11; load = 1'b1; poke = 1'b0; poke_p = 0; poke_addr = '0; poke_data = '0;
        a_req_d = '0; a_we_d = '0; a_addr_d = '0; a_wdata_d = '0;
        b_req_d = '0; b_we_d = '0; b_addr_d = '0; b_wdata_d = '0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 512; i++) shadow[p][i] = pat(p, i);
        @(posedge clk);
        @(posedge clk);
        load = 1'b0;

        test_reset();
        test_a_read();
        test_b_write();
        test_addr_change();
        test_reset_mid();
        test_round_robin();
        test_fixed_prio();
        test_random(0, 120);
        test_random(1, 120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
